// File: rtl/wb_burst_sram_ctrl_if.sv
// Wishbone B3 signal bundle between the core's external bus master and the
// burst SRAM controller. The master modport drives requests; the slave modport
// answers with data and ack/err/rty. AW is the byte-address width.
interface wb_burst_sram_ctrl_if #(
   parameter int AW = 32
);
   logic [AW-1:0] wb_adr_i;
   logic [31:0]   wb_dat_i;
   logic [3:0]    wb_sel_i;
   logic          wb_we_i;
   logic          wb_cyc_i;
   logic          wb_stb_i;
   logic [2:0]    wb_cti_i;
   logic [1:0]    wb_bte_i;
   logic [31:0]   wb_dat_o;
   logic          wb_ack_o;
   logic          wb_err_o;
   logic          wb_rty_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
             wb_cti_i, wb_bte_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
             wb_cti_i, wb_bte_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );
endinterface

// File: rtl/wb_burst_sram_ctrl.sv
// Purpose : Wishbone B3 slave (classic + CTI/BTE bursts) driving a single-port
//           synchronous SRAM with one-cycle read latency; out-of-range -> err.
// Latency : classic ack one clock after stb (2 clocks/transfer); bursts ack
//           first beat one clock after stb, then one beat per clock.
// Backpressure: master wait states (stb low, cyc high) stall the burst with no
//           ack and the pending read is reissued; cyc low aborts to IDLE.
// Ports   : clk, rst_n (async active-low); wb (slave modport of
//           wb_burst_sram_ctrl_if); sram_en/we/be/addr/wdata to the SRAM,
//           sram_rdata from it (wb_dat_o passes it straight through).
module wb_burst_sram_ctrl #(
   parameter  int MEM_WORDS = 1024,
   parameter  int AW        = 32,
   localparam int SAW       = $clog2(MEM_WORDS)
) (
   input  logic                clk,
   input  logic                rst_n,
   wb_burst_sram_ctrl_if.slave wb,
   output logic                sram_en,
   output logic                sram_we,
   output logic [3:0]          sram_be,
   output logic [SAW-1:0]      sram_addr,
   output logic [31:0]         sram_wdata,
   input  logic [31:0]         sram_rdata
);

   localparam logic [2:0]    CTI_CONST = 3'b001;
   localparam logic [2:0]    CTI_INCR  = 3'b010;
   localparam logic [2:0]    CTI_EOB   = 3'b111;
   localparam logic [AW-3:0] MEM_LIMIT = (AW-2)'(MEM_WORDS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      BURST  = 2'd2,
      ERR    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   // One extra MSB so a linear burst running past the top word is visible
   // as out of range instead of silently wrapping to word 0.
   logic [SAW:0]  cnt_q, cnt_d;
   // Direction is latched at acceptance so wait-state cycles, where the
   // master's we may be meaningless, still behave as the burst requires.
   logic          we_q, we_d;

   logic [AW-3:0] idx;
   logic          idx_in_range;
   logic          cnt_in_range;
   logic          beat;
   logic [SAW:0]  cnt_nxt;

   logic          ack_c, err_c, en_c, we_c;
   logic [SAW-1:0] addr_c;

   logic          unused_adr_lsb;
   assign unused_adr_lsb = &{1'b0, wb.wb_adr_i[1:0]};

   assign idx          = wb.wb_adr_i[AW-1:2];
   assign idx_in_range = (idx < MEM_LIMIT);
   assign cnt_in_range = ~cnt_q[SAW];
   assign beat         = wb.wb_cyc_i & wb.wb_stb_i;

   // Address of the beat after cnt. Constant bursts stay put, linear ones
   // step by one, wrap-N bursts step only the low log2(N) bits.
   function automatic logic [SAW:0] next_addr(input logic [SAW:0] c,
                                              input logic [2:0]   cti,
                                              input logic [1:0]   bte);
      logic [SAW:0] inc;
      logic [SAW:0] r;
      inc = c + (SAW+1)'(1);
      r   = inc;
      if (cti == CTI_CONST) begin
         r = c;
      end else begin
         case (bte)
            2'b00:   r = inc;
            2'b01:   r = {c[SAW:2], inc[1:0]};
            2'b10:   r = {c[SAW:3], inc[2:0]};
            default: r = {c[SAW:4], inc[3:0]};
         endcase
      end
      return r;
   endfunction

   assign cnt_nxt = next_addr(cnt_q, wb.wb_cti_i, wb.wb_bte_i);

   // Bus and SRAM strobes are decoded from the registered state and the
   // live request: the SRAM read must launch in the acceptance cycle and
   // burst acks follow stb in the same cycle, so registering them would
   // cost a clock per beat.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      ack_c   = 1'b0;
      err_c   = 1'b0;
      en_c    = 1'b0;
      we_c    = 1'b0;
      addr_c  = cnt_q[SAW-1:0];

      case (state_q)
         IDLE: begin
            if (beat) begin
               cnt_d = idx[SAW:0];
               we_d  = wb.wb_we_i;
               if (!idx_in_range) begin
                  state_d = ERR;
               end else begin
                  if (wb.wb_cti_i == CTI_CONST || wb.wb_cti_i == CTI_INCR) begin
                     state_d = BURST;
                  end else begin
                     state_d = SINGLE;
                  end
                  // Launch the read now so data is on sram_rdata for the ack.
                  if (!wb.wb_we_i) begin
                     en_c   = 1'b1;
                     addr_c = idx[SAW-1:0];
                  end
               end
            end
         end

         SINGLE: begin
            state_d = IDLE;
            if (wb.wb_cyc_i) begin
               ack_c = 1'b1;
               if (we_q) begin
                  en_c = 1'b1;
                  we_c = 1'b1;
               end
            end
         end

         ERR: begin
            state_d = IDLE;
            err_c   = wb.wb_cyc_i;
         end

         BURST: begin
            if (!wb.wb_cyc_i) begin
               state_d = IDLE;
            end else begin
               if (beat && cnt_in_range) begin
                  ack_c = 1'b1;
                  cnt_d = cnt_nxt;
                  if (wb.wb_cti_i == CTI_EOB) begin
                     state_d = IDLE;
                  end
               end
               if (beat && !cnt_in_range) begin
                  err_c   = 1'b1;
                  state_d = IDLE;
               end
               if (we_q) begin
                  en_c = ack_c;
                  we_c = ack_c;
               end else begin
                  // Read ahead: on an ack fetch the following beat's word,
                  // otherwise refetch the pending one so a wait state
                  // neither skips nor repeats a word.
                  en_c   = 1'b1;
                  addr_c = ack_c ? cnt_nxt[SAW-1:0] : cnt_q[SAW-1:0];
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
      end
   end

   // Gating with rst_n makes reset take effect within the cycle it is
   // asserted, so a write in flight when reset hits never reaches the SRAM.
   assign wb.wb_ack_o = rst_n & ack_c;
   assign wb.wb_err_o = rst_n & err_c;
   assign wb.wb_rty_o = 1'b0;
   assign wb.wb_dat_o = sram_rdata;

   assign sram_en    = rst_n & en_c;
   assign sram_we    = rst_n & we_c;
   assign sram_be    = wb.wb_sel_i;
   assign sram_addr  = addr_c;
   assign sram_wdata = wb.wb_dat_i;

endmodule

// File: tb/tb_wb_burst_sram_ctrl.sv
// Bench for wb_burst_sram_ctrl: directed test-plan steps followed by random
// classic/burst traffic, checked against a word-array reference memory and
// beat addresses computed directly from the burst rules.
module tb_wb_burst_sram_ctrl;
   localparam int MW  = 1024;
   localparam int SAW = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_burst_sram_ctrl_if #(.AW(32)) bus ();

   logic           sram_en, sram_we;
   logic [3:0]     sram_be;
   logic [SAW-1:0] sram_addr;
   logic [31:0]    sram_wdata, sram_rdata;

   wb_burst_sram_ctrl #(.MEM_WORDS(MW), .AW(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb         (bus),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_be    (sram_be),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   // SRAM model: word k preloaded with k, one-cycle read latency.
   logic [31:0] mem [MW];
   bit          loaded;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < MW; i++) mem[i] <= 32'(i);
         loaded <= 1'b1;
      end else if (sram_en) begin
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   logic [31:0] ref_mem [MW];
   int tests;
   int fails;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_drive(input bit cyc, input bit stb, input bit we,
                            input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [2:0] cti,
                            input logic [1:0] bte);
      bus.wb_cyc_i = cyc;
      bus.wb_stb_i = stb;
      bus.wb_we_i  = we;
      bus.wb_adr_i = adr;
      bus.wb_dat_i = dat;
      bus.wb_sel_i = sel;
      bus.wb_cti_i = cti;
      bus.wb_bte_i = bte;
   endtask

   task automatic bus_idle();
      bus_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_ref(input int a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
   endtask

   // Word index of beat k: constant stays at start, linear counts up,
   // wrap-N walks the aligned N-word block starting from start.
   function automatic int beat_addr(input int start, input int k, input int mode, input int bte);
      int n;
      if (mode == 1) return start;
      if (bte == 0) return start + k;
      n = 2 ** (bte + 1);
      return (start / n) * n + (start + k) % n;
   endfunction

   task automatic idle_chk(input string tag);
      bus_idle();
      @(negedge clk);
      chk({tag, ".idle"}, 32'({bus.wb_ack_o, bus.wb_err_o}), 32'h0);
      next_cycle();
   endtask

   task automatic classic(input bit we, input int adr, input logic [31:0] dat,
                          input logic [3:0] sel, input string tag);
      int idx;
      bit inr;
      idx = adr >> 2;
      inr = (idx < MW);
      bus_drive(1'b1, 1'b1, we, 32'(adr), dat, sel, 3'b000, 2'b00);
      @(negedge clk);
      chk({tag, ".acc_resp"}, 32'({bus.wb_ack_o, bus.wb_err_o}), 32'h0);
      chk({tag, ".acc_en"}, 32'(sram_en), 32'(!we && inr));
      if (!we && inr) chk({tag, ".acc_addr"}, 32'(sram_addr), 32'(idx));
      next_cycle();
      @(negedge clk);
      chk({tag, ".resp"}, 32'({bus.wb_ack_o, bus.wb_err_o}), inr ? 32'h2 : 32'h1);
      if (!inr) chk({tag, ".no_sram"}, 32'(sram_en), 32'h0);
      if (inr && !we) chk({tag, ".rdata"}, bus.wb_dat_o, ref_mem[idx]);
      if (inr && we) begin
         chk({tag, ".we"}, 32'({sram_en, sram_we, sram_be}), 32'({2'b11, sel}));
         chk({tag, ".waddr"}, 32'(sram_addr), 32'(idx));
      end
      next_cycle();
      if (inr && we) wr_ref(idx, dat, sel);
   endtask

   // mode: 1 constant, 2 incrementing. gap_after: beat after which stb is
   // dropped for gap_len cycles (-1 for none). The last beat carries CTI 111.
   task automatic burst(input bit we, input int start, input int mode, input int bte,
                        input int n, input int gap_after, input int gap_len,
                        input string tag);
      logic [31:0] d;
      logic [3:0]  s;
      int a;
      d = $urandom;
      s = we ? 4'($urandom_range(1, 15)) : 4'hf;
      bus_drive(1'b1, 1'b1, we, 32'(start << 2), d, s, 3'(mode), 2'(bte));
      @(negedge clk);
      chk({tag, ".acc_resp"}, 32'({bus.wb_ack_o, bus.wb_err_o}), 32'h0);
      if (!we) chk({tag, ".acc_rd"}, 32'({sram_en, sram_addr}), 32'({1'b1, 10'(start)}));
      next_cycle();
      for (int k = 0; k < n; k++) begin
         a = beat_addr(start, k, mode, bte);
         if (k > 0) begin
            d = $urandom;
            s = we ? 4'($urandom_range(1, 15)) : 4'hf;
         end
         bus_drive(1'b1, 1'b1, we, 32'(a << 2), d, s,
                   (k == n - 1) ? 3'b111 : 3'(mode), 2'(bte));
         @(negedge clk);
         if (a >= MW) begin
            chk({tag, ".oor"}, 32'({bus.wb_ack_o, bus.wb_err_o, sram_we}), 32'h2);
            next_cycle();
            break;
         end
         chk({tag, ".beat"}, 32'({bus.wb_ack_o, bus.wb_err_o}), 32'h2);
         if (we) begin
            chk({tag, ".we"}, 32'({sram_we, sram_be}), 32'({1'b1, s}));
            chk({tag, ".waddr"}, 32'(sram_addr), 32'(a));
         end else begin
            chk({tag, ".rdata"}, bus.wb_dat_o, ref_mem[a]);
         end
         next_cycle();
         if (we) wr_ref(a, d, s);
         if (k == gap_after) begin
            for (int g = 0; g < gap_len; g++) begin
               bus_drive(1'b1, 1'b0, we, 32'(a << 2), d, s, 3'(mode), 2'(bte));
               @(negedge clk);
               chk({tag, ".gap"}, 32'({bus.wb_ack_o, bus.wb_err_o}), 32'h0);
               next_cycle();
            end
         end
      end
   endtask

   initial begin
      logic [31:0] d0, d1;
      int mism;
      tests = 0;
      fails = 0;
      for (int i = 0; i < MW; i++) ref_mem[i] = 32'(i);

      // Reset holds everything quiet even with a request on the bus.
      rst_n = 1'b0;
      bus_drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hf, 3'b000, 2'b00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.outs", 32'({bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o, sram_en, sram_we}), 32'h0);
      next_cycle();
      bus_idle();
      rst_n = 1'b1;

      classic(1'b1, 32'h40, 32'hDEADBEEF, 4'hf, "cl_wr40");
      classic(1'b0, 32'h40, 32'h0, 4'hf, "cl_rd40");
      idle_chk("after_cl");

      // 4-beat linear read from 0x100, then straight into a classic read
      // whose acceptance cycle must not see an ack (burst back in IDLE).
      burst(1'b0, 32'h40, 2, 0, 4, -1, 0, "lin_rd");
      classic(1'b0, 32'h44, 32'h0, 4'hf, "post_lin");

      // Wrap-4 write from index 6 lands at 6,7,4,5.
      burst(1'b1, 6, 2, 1, 4, -1, 0, "wrap4_wr");
      for (int i = 4; i < 8; i++) classic(1'b0, i << 2, 32'h0, 4'hf, "wrap4_rb");

      // Wait state of two cycles after beat 2.
      burst(1'b0, 300, 2, 0, 5, 1, 2, "gap_rd");

      // Out of range: classic and a linear burst crossing the top word.
      classic(1'b0, 32'h1000, 32'h0, 4'hf, "oor_cl");
      burst(1'b0, MW - 2, 2, 0, 4, -1, 0, "oor_lin");
      classic(1'b0, 32'h8, 32'h0, 4'hf, "post_oor");
      idle_chk("post_oor");

      // Reset during beat 2 of a write burst.
      d0 = $urandom;
      d1 = $urandom;
      bus_drive(1'b1, 1'b1, 1'b1, 32'(200 << 2), d0, 4'hf, 3'b010, 2'b00);
      next_cycle();
      @(negedge clk);
      chk("rstb.b1", 32'({bus.wb_ack_o, sram_we}), 32'h3);
      next_cycle();
      wr_ref(200, d0, 4'hf);
      bus_drive(1'b1, 1'b1, 1'b1, 32'(201 << 2), d1, 4'hf, 3'b010, 2'b00);
      #1;
      chk("rstb.b2_pre", 32'({bus.wb_ack_o, sram_we}), 32'h3);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstb.b2_drop", 32'({bus.wb_ack_o, bus.wb_err_o, sram_en, sram_we}), 32'h0);
      chk("rstb.rty", 32'(bus.wb_rty_o), 32'h0);
      next_cycle();
      bus_idle();
      rst_n = 1'b1;
      classic(1'b0, 201 << 2, 32'h0, 4'hf, "rstb.rd201");
      classic(1'b0, 200 << 2, 32'h0, 4'hf, "rstb.rd200");

      // Random mix of classic and burst traffic.
      for (int r = 0; r < 40; r++) begin
         int op;
         int n;
         op = int'($urandom_range(0, 3));
         n  = int'($urandom_range(2, 8));
         if (op == 0) begin
            classic(1'($urandom_range(0, 1)), int'($urandom_range(0, MW + 15)) << 2,
                    $urandom, 4'($urandom_range(1, 15)), "rnd_cl");
         end else begin
            burst(1'($urandom_range(0, 1)), int'($urandom_range(0, MW - 1)),
                  (op == 1) ? 1 : 2, int'($urandom_range(0, 3)), n,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 2)) : -1,
                  int'($urandom_range(1, 3)), "rnd_bu");
         end
         if ($urandom_range(0, 3) == 0) idle_chk("rnd");
      end

      // Whole-array check: catches stray or missing writes.
      bus_idle();
      next_cycle();
      mism = 0;
      for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) mism++;
      chk("mem_image", 32'(mism), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
